hex_display_arbiter: RTL

HEX_DISPLAY_ARBITER -- requirements
Module: hex_display_arbiter

---
 rtl/hex_display_arbiter.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/hex_display_arbiter.sv
// hex_display_arbiter: arbitrates CPU/debug display requests and scans the accepted value onto eight 7-segment digits.
// Latency: grant at edge N -> ack N..N+1, HEX0 written edge N+1, HEX7 edge N+8, done pulse after edge N+9.
// Backpressure: requests arriving while busy (SCAN/DONE) are ignored; requesters hold req until their ack.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   cpu_req/cpu_data/cpu_ack      CPU request, 32-bit value, one-cycle accept pulse
//   dbg_req/dbg_data/dbg_ack      debug request, 32-bit value, one-cycle accept pulse
//   busy                          high while scanning (SCAN or DONE)
//   done                          one-cycle pulse once all eight digits are written
//   hex_value                     last accepted value
//   HEX0..HEX7                    active-low segments gfedcba, HEX0 = nibble [3:0]
// Parameter FIXED_PRIO: 0 = round-robin, 1 = CPU always wins a tie.
// Optional macro HEX_BLANK_EN: leading-zero blanking of digits 7..1.
module hex_display_arbiter #(
  parameter int FIXED_PRIO = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic [31:0] cpu_data,
  output logic        cpu_ack,
  input  logic        dbg_req,
  input  logic [31:0] dbg_data,
  output logic        dbg_ack,
  output logic        busy,
  output logic        done,
  output logic [31:0] hex_value,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3,
  output logic [6:0]  HEX4,
  output logic [6:0]  HEX5,
  output logic [6:0]  HEX6,
  output logic [6:0]  HEX7
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

  state_e      state_q, state_d;
  logic [2:0]  digit_q, digit_d;
  logic [31:0] value_q, value_d;
  logic        cpu_ack_q, cpu_ack_d;
  logic        dbg_ack_q, dbg_ack_d;
  logic        done_q, done_d;
  // Set when the debug source holds priority for the next tie (CPU went last).
  logic        prio_dbg_q, prio_dbg_d;
  logic [6:0]  seg_q [8];

  logic        grant_cpu, grant_dbg;
  logic        seg_we;
  logic [3:0]  nibble;
  logic [6:0]  seg_dec;
  logic [6:0]  seg_code;

  // Single shared decoder: the nibble under the scan pointer.
  assign nibble = value_q[{digit_q, 2'b00} +: 4];

  always_comb begin
    seg_dec = 7'h7F;
    case (nibble)
      4'h0: seg_dec = 7'h40;
      4'h1: seg_dec = 7'h79;
      4'h2: seg_dec = 7'h24;
      4'h3: seg_dec = 7'h30;
      4'h4: seg_dec = 7'h19;
      4'h5: seg_dec = 7'h12;
      4'h6: seg_dec = 7'h02;
      4'h7: seg_dec = 7'h78;
      4'h8: seg_dec = 7'h00;
      4'h9: seg_dec = 7'h10;
      4'hA: seg_dec = 7'h08;
      4'hB: seg_dec = 7'h03;
      4'hC: seg_dec = 7'h46;
      4'hD: seg_dec = 7'h21;
      4'hE: seg_dec = 7'h06;
      4'hF: seg_dec = 7'h0E;
      default: seg_dec = 7'h7F;
    endcase
  end

`ifdef HEX_BLANK_EN
  // Digit k is blank when nibbles 7..k are all zero; digit 0 always shows.
  logic [31:0] upper;
  assign upper    = value_q >> {digit_q, 2'b00};
  assign seg_code = ((digit_q != 3'd0) && (upper == 32'd0)) ? 7'h7F : seg_dec;
`else
  assign seg_code = seg_dec;
`endif

  // Tie-break: fixed mode favours the CPU; round-robin favours whoever was not granted last.
  always_comb begin
    if (FIXED_PRIO != 0) begin
      grant_cpu = cpu_req;
    end else begin
      grant_cpu = cpu_req & ~(dbg_req & prio_dbg_q);
    end
    grant_dbg = dbg_req & ~grant_cpu;
  end

  always_comb begin
    state_d    = state_q;
    digit_d    = digit_q;
    value_d    = value_q;
    cpu_ack_d  = 1'b0;
    dbg_ack_d  = 1'b0;
    done_d     = 1'b0;
    prio_dbg_d = prio_dbg_q;
    seg_we     = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_cpu || grant_dbg) begin
          value_d    = grant_cpu ? cpu_data : dbg_data;
          cpu_ack_d  = grant_cpu;
          dbg_ack_d  = grant_dbg;
          prio_dbg_d = grant_cpu;
          digit_d    = 3'd0;
          state_d    = SCAN;
        end
      end
      SCAN: begin
        seg_we  = 1'b1;
        digit_d = digit_q + 3'd1;
        if (digit_q == 3'd7) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      digit_q    <= 3'd0;
      value_q    <= 32'd0;
      cpu_ack_q  <= 1'b0;
      dbg_ack_q  <= 1'b0;
      done_q     <= 1'b0;
      prio_dbg_q <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        seg_q[i] <= 7'h7F;
      end
    end else begin
      state_q    <= state_d;
      digit_q    <= digit_d;
      value_q    <= value_d;
      cpu_ack_q  <= cpu_ack_d;
      dbg_ack_q  <= dbg_ack_d;
      done_q     <= done_d;
      prio_dbg_q <= prio_dbg_d;
      if (seg_we) begin
        seg_q[digit_q] <= seg_code;
      end
    end
  end

  assign cpu_ack   = cpu_ack_q;
  assign dbg_ack   = dbg_ack_q;
  assign done      = done_q;
  assign busy      = (state_q != IDLE);
  assign hex_value = value_q;
  assign HEX0      = seg_q[0];
  assign HEX1      = seg_q[1];
  assign HEX2      = seg_q[2];
  assign HEX3      = seg_q[3];
  assign HEX4      = seg_q[4];
  assign HEX5      = seg_q[5];
  assign HEX6      = seg_q[6];
  assign HEX7      = seg_q[7];

endmodule
